// File: rtl/tenkey_pkg.sv
// Shared key codes, keypad layout and code-to-one-hot helper for the tenkey scanner.
package tenkey_pkg;

  typedef enum logic [3:0] {
    KEY_0    = 4'd0,
    KEY_1    = 4'd1,
    KEY_2    = 4'd2,
    KEY_3    = 4'd3,
    KEY_4    = 4'd4,
    KEY_5    = 4'd5,
    KEY_6    = 4'd6,
    KEY_7    = 4'd7,
    KEY_8    = 4'd8,
    KEY_9    = 4'd9,
    KEY_STAR = 4'd10,
    KEY_HASH = 4'd11,
    KEY_NONE = 4'd15
  } key_code_t;

  localparam int NUM_KEYS = 12;

  // Entry index is row*3 + col, columns numbered left to right.
  localparam key_code_t KEY_LAYOUT [NUM_KEYS] = '{
    KEY_1, KEY_2, KEY_3,
    KEY_4, KEY_5, KEY_6,
    KEY_7, KEY_8, KEY_9,
    KEY_STAR, KEY_0, KEY_HASH
  };

  function automatic logic [9:0] keyToOneHot(input key_code_t k);
    logic [9:0] oh;
    oh = '0;
    for (int i = 0; i < 10; i++) begin
      oh[i] = (4'(k) == 4'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/tenkey_debounce.sv
// Accepts a scan code only after DEBOUNCE consecutive identical completed scans.
module tenkey_debounce
  import tenkey_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_scanDone,
  input  key_code_t i_code,
  output key_code_t o_accepted
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  key_code_t r_candidate;
  key_code_t r_accepted;
  logic [CW-1:0] r_count;
  key_code_t w_candNext;
  logic [CW-1:0] w_countNext;

  always_comb begin
    w_candNext  = r_candidate;
    w_countNext = r_count;
    if (i_scanDone) begin
      if (i_code == r_candidate) begin
        w_countNext = (r_count == CW'(DEBOUNCE)) ? r_count : r_count + 1'b1;
      end else begin
        w_candNext  = i_code;
        w_countNext = CW'(1);
      end
    end
  end

  // Acceptance uses the post-update count so DEBOUNCE=1 accepts on the first scan.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_candidate <= KEY_NONE;
      r_count     <= '0;
      r_accepted  <= KEY_NONE;
    end else begin
      r_candidate <= w_candNext;
      r_count     <= w_countNext;
      if (i_scanDone && (w_countNext == CW'(DEBOUNCE))) begin
        r_accepted <= w_candNext;
      end
    end
  end

  assign o_accepted = r_accepted;

endmodule

// File: rtl/tenkey_scan.sv
// 4x3 keypad scanner producing debounced one-hot tenkey[9:0] and close ('#').
// Define TENKEY_SCAN_SYNC_EN to pass row through a 2-flop synchronizer.
module tenkey_scan
  import tenkey_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [9:0] tenkey,
  output logic       close
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [TW-1:0] r_timer;
  logic [1:0]    r_colIdx;
  logic [11:0]   r_snap;
  logic [9:0]    r_tenkey;
  logic          r_close;
  logic [11:0]   w_snapNext;
  logic [3:0]    w_row;
  logic          w_sample;
  logic          w_scanDone;
  key_code_t     w_hit;
  key_code_t     w_scanCode;
  key_code_t     w_accepted;

`ifdef TENKEY_SCAN_SYNC_EN
  logic [3:0] r_rowMeta;
  logic [3:0] r_rowSync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rowMeta <= 4'b1111;
      r_rowSync <= 4'b1111;
    end else begin
      r_rowMeta <= row;
      r_rowSync <= r_rowMeta;
    end
  end

  assign w_row = r_rowSync;
`else
  assign w_row = row;
`endif

  assign w_sample   = (r_timer == TW'(SCAN_DIV - 1));
  assign w_scanDone = w_sample && (r_colIdx == 2'd2);
  assign col        = ~(3'b001 << r_colIdx);

  // Decode from the snapshot as it will be after this sample, so the code is
  // ready in the same cycle the last column is captured.
  always_comb begin
    w_snapNext = r_snap;
    if (w_sample) begin
      for (int r = 0; r < 4; r++) begin
        w_snapNext[4'(r * 3) + {2'b00, r_colIdx}] = ~w_row[r];
      end
    end
    w_hit = KEY_NONE;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (w_snapNext[i]) w_hit = KEY_LAYOUT[i];
    end
    w_scanCode = ($countones(w_snapNext) == 1) ? w_hit : KEY_NONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer  <= '0;
      r_colIdx <= 2'd0;
      r_snap   <= '0;
    end else begin
      r_snap <= w_snapNext;
      if (w_sample) begin
        r_timer  <= '0;
        r_colIdx <= (r_colIdx == 2'd2) ? 2'd0 : r_colIdx + 2'd1;
      end else begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  tenkey_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .i_scanDone(w_scanDone),
    .i_code    (w_scanCode),
    .o_accepted(w_accepted)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tenkey <= '0;
      r_close  <= 1'b0;
    end else begin
      r_tenkey <= keyToOneHot(w_accepted);
      r_close  <= (w_accepted == KEY_HASH);
    end
  end

  assign tenkey = r_tenkey;
  assign close  = r_close;

endmodule

// File: tb/tb_tenkey_scan.sv
// Directed bench for tenkey_scan with SCAN_DIV=4, DEBOUNCE=2 (12-clock scan).
module tb_tenkey_scan;

  localparam logic [11:0] K1 = 12'b0000_0000_0001;
  localparam logic [11:0] K2 = 12'b0000_0000_0010;
  localparam logic [11:0] K3 = 12'b0000_0000_0100;
  localparam logic [11:0] K5 = 12'b0000_0001_0000;
  localparam logic [11:0] K8 = 12'b0000_1000_0000;
  localparam logic [11:0] K9 = 12'b0001_0000_0000;
  localparam logic [11:0] KS = 12'b0010_0000_0000;
  localparam logic [11:0] K0 = 12'b0100_0000_0000;
  localparam logic [11:0] KH = 12'b1000_0000_0000;

  typedef struct {
    string       name;
    logic [11:0] keys;
    int          scans;
    logic [9:0]  expTenkey;
    logic        expClose;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  row;
  logic [2:0]  col;
  logic [9:0]  tenkey;
  logic        close;
  logic [11:0] keys;
  int          total = 0;
  int          bad = 0;
  vec_t        vecs[$];

  always #5 clock = ~clock;

  tenkey_scan #(
    .SCAN_DIV(4),
    .DEBOUNCE(2)
  ) dut (
    .clk   (clock),
    .reset (reset),
    .row   (row),
    .col   (col),
    .tenkey(tenkey),
    .close (close)
  );

  // Keypad model: a row reads low when any pressed key in it sits on the driven column.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      row[r] = ~(|(keys[r*3 +: 3] & ~col));
    end
  end

  task automatic checkOutput(input string name, input logic [9:0] expT, input logic expC);
    total++;
    if (tenkey !== expT || close !== expC) begin
      bad++;
      $display("[TB] FAIL %s: tenkey=%b close=%b, expected tenkey=%b close=%b",
               name, tenkey, close, expT, expC);
    end
  endtask

  task automatic checkCol(input string name, input logic [2:0] expCol);
    total++;
    if (col !== expCol) begin
      bad++;
      $display("[TB] FAIL %s: col=%b, expected col=%b", name, col, expCol);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] k, input int scans);
    keys = k;
    repeat (scans * 12) @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs.push_back('{"k5 scan1",    K5,      1, 10'b0000000000, 1'b0});
    vecs.push_back('{"k5 scan2",    K5,      1, 10'b0000100000, 1'b0});
    vecs.push_back('{"k5 hold",     K5,      3, 10'b0000100000, 1'b0});
    vecs.push_back('{"rel5 scan1",  12'h000, 1, 10'b0000100000, 1'b0});
    vecs.push_back('{"rel5 scan2",  12'h000, 1, 10'b0000000000, 1'b0});
    vecs.push_back('{"k3 glitch",   K3,      1, 10'b0000000000, 1'b0});
    vecs.push_back('{"rel3 a",      12'h000, 1, 10'b0000000000, 1'b0});
    vecs.push_back('{"rel3 b",      12'h000, 2, 10'b0000000000, 1'b0});
    vecs.push_back('{"k1k9 a",      K1 | K9, 1, 10'b0000000000, 1'b0});
    vecs.push_back('{"k1k9 hold",   K1 | K9, 3, 10'b0000000000, 1'b0});
    vecs.push_back('{"k1 only a",   K1,      1, 10'b0000000000, 1'b0});
    vecs.push_back('{"k1 only b",   K1,      1, 10'b0000000010, 1'b0});
    vecs.push_back('{"hash a",      KH,      1, 10'b0000000010, 1'b0});
    vecs.push_back('{"hash b",      KH,      1, 10'b0000000000, 1'b1});
    vecs.push_back('{"hash c",      KH,      1, 10'b0000000000, 1'b1});
    vecs.push_back('{"star a",      KS,      1, 10'b0000000000, 1'b1});
    vecs.push_back('{"star b",      KS,      1, 10'b0000000000, 1'b0});
    vecs.push_back('{"star c",      KS,      1, 10'b0000000000, 1'b0});
    vecs.push_back('{"k2",          K2,      2, 10'b0000000100, 1'b0});
    vecs.push_back('{"k2to5 a",     K5,      1, 10'b0000000100, 1'b0});
    vecs.push_back('{"k2to5 b",     K5,      1, 10'b0000100000, 1'b0});
    vecs.push_back('{"k8",          K8,      2, 10'b0100000000, 1'b0});
    vecs.push_back('{"k0",          K0,      2, 10'b0000000001, 1'b0});

    keys  = 12'h000;
    reset = 1'b1;
    #2;
    checkOutput("reset outputs", 10'b0000000000, 1'b0);
    checkCol("reset col", 3'b110);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Column rotation: each column held for 4 clocks.
    @(negedge clock);
    checkCol("col0 phase", 3'b110);
    repeat (4) @(negedge clock);
    checkCol("col1 phase", 3'b101);
    repeat (4) @(negedge clock);
    checkCol("col2 phase", 3'b011);
    repeat (4) @(negedge clock);
    checkCol("col0 again", 3'b110);
    checkOutput("idle after scan", 10'b0000000000, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].keys, vecs[i].scans);
      checkOutput(vecs[i].name, vecs[i].expTenkey, vecs[i].expClose);
    end

    // Reset mid-scan while '0' is accepted and still held.
    repeat (5) @(negedge clock);
    checkCol("pre-reset col1", 3'b101);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async reset outputs", 10'b0000000000, 1'b0);
    checkCol("async reset col", 3'b110);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    applyStimulus(K0, 1);
    checkOutput("rearm scan1", 10'b0000000000, 1'b0);
    repeat (11) @(negedge clock);
    checkOutput("rearm before out edge", 10'b0000000000, 1'b0);
    @(negedge clock);
    checkOutput("rearm after out edge", 10'b0000000001, 1'b0);
    applyStimulus(12'h000, 2);
    checkOutput("final release", 10'b0000000000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
